if_fetch: RTL
=============

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0): bubble instruction presented to ID.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 IFWrite  input  1  ID accepts a new IF/ID word this cycle; 0 = load-use stall, hold.
REQ-006 Branch  input  1  taken conditional branch for the instruction in ID.
REQ-007 Jump  input  1  JAL/JALR in ID.
REQ-008 JumpAddr  input  32  redirect target from ID.
REQ-009 imem_req  output  1  instruction memory request; held until granted.
REQ-010 imem_addr  output  32  word-aligned fetch address; stable while imem_req=1.
REQ-011 imem_gnt  input  1  memory accepts request (imem_req & imem_gnt = transfer).
REQ-012 imem_valid  input  1  read data valid; one response per granted request, in order, >=1 cycle after grant.
REQ-013 imem_rdata  input  32  instruction word.
REQ-014 Instruction_id  output  32  IF/ID instruction register.
REQ-015 PC_id  output  32  IF/ID PC register.

Function
REQ-016 Redirect = (Branch | Jump) & IFWrite; Branch/Jump SHALL be ignored while IFWrite=0.
REQ-017 Redirect target SHALL be {JumpAddr[31:2],2'b00}.
REQ-018 Fetch PC SHALL advance by 4 on each grant, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-019 At most one request SHALL be outstanding (granted, response pending).
REQ-020 A 2-entry in-order queue SHALL hold {PC, instruction} responses not yet consumed by ID.
REQ-021 FSM states: REQ (imem_req=1), WAIT (granted, awaiting imem_valid), DISCARD (awaiting a response to drop).
REQ-022 REQ: imem_req asserted only if queue occupancy < 2; grant -> WAIT; redirect without grant -> imem_addr becomes target next cycle, stay REQ; redirect with grant -> WAIT->DISCARD semantics (response dropped), fetch PC = target.
REQ-023 WAIT: imem_valid without redirect -> push queue, -> REQ; redirect (with or without imem_valid same cycle) -> fetch PC = target; with imem_valid -> drop, REQ; without -> DISCARD.
REQ-024 DISCARD: imem_valid -> drop response, -> REQ; further redirect -> update fetch PC only.
REQ-025 IFWrite=1: redirect -> Instruction_id=NOP_INSTR, PC_id=0, queue flushed; else queue non-empty -> pop head into IF/ID; else -> NOP_INSTR, PC_id=0.
REQ-026 IFWrite=0: Instruction_id, PC_id and queue head SHALL hold; queue push still allowed if not full.
REQ-027 Push and pop in the same cycle SHALL keep occupancy unchanged; push at occupancy 2 SHALL not occur (guaranteed by REQ-022).
REQ-028 Minimum latency: response on cycle N with IFWrite=1 and empty queue SHALL appear on Instruction_id at edge N+1 (push and bypass-pop same cycle).

Reset
REQ-029 On reset: fetch PC=RESET_PC, state=REQ, imem_req=0, queue empty, Instruction_id=NOP_INSTR, PC_id=0.
REQ-030 imem_req SHALL first assert the cycle after reset deasserts; a response arriving during or after reset for a pre-reset request SHALL be the memory's responsibility (memory reset together).

Structure
REQ-031 NOP_INSTR, RESET_PC default and the 32-bit word width SHALL live in the shared RISC-V defines package rv_defs_pkg.
REQ-032 The 2-entry queue SHALL be a sub-module fetch_queue (push, pop, flush, full, empty, head data).

Verification
REQ-033 Reset, zero-wait memory (gnt=1, valid 1 cycle later), IFWrite=1 -> PC_id sequence 0x0,0x4,0x8 on consecutive issued words, NOP before first.
REQ-034 IFWrite=0 for 3 cycles while streaming -> IF/ID frozen, queue fills to 2, imem_req drops; release -> no word lost or duplicated.
REQ-035 Jump=1, JumpAddr=0x0000_0103 with request outstanding -> IF/ID=NOP, pending response dropped, next imem_addr=0x0000_0100.
REQ-036 Branch=1 with IFWrite=0 -> no redirect; same Branch with IFWrite=1 next cycle -> redirect taken.
REQ-037 Redirect to 0xFFFF_FFFC -> following fetch addresses 0xFFFF_FFFC, 0x0000_0000.
REQ-038 reset asserted in WAIT with queue holding 1 entry -> all outputs return to REQ-029 values next edge.

Source files
------------

// File: rtl/rv_defs_pkg.sv
// Shared RISC-V definitions: word width, canonical NOP, reset vector and
// the types used by the instruction-fetch stage.
package rv_defs_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t RV_NOP      = 32'h0000_0013;  // addi x0,x0,0
  localparam word_t RV_RESET_PC = 32'h0000_0000;
  localparam word_t WORD_MASK   = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    FS_REQ,
    FS_WAIT,
    FS_DISCARD
  } fetch_state_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  function automatic word_t word_align(input word_t addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry in-order queue of fetched {PC, instruction} pairs. When empty,
// the head shows the incoming push data so a same-cycle push+pop bypasses.
module fetch_queue
  import rv_defs_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output fetch_entry_t head_data,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  fetch_entry_t mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         bypass, do_write, do_read;

  // NOTE: every variable gets a default at the top of always_comb so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    bypass   = push & pop & (count_q == 2'd0);
    do_write = push & ~flush & ~bypass & (count_q != 2'd2);
    do_read  = pop & ~flush & (count_q != 2'd0);
    wr_ptr_d = wr_ptr_q ^ do_write;
    rd_ptr_d = rd_ptr_q ^ do_read;
    count_d  = count_q;
    case ({do_write, do_read})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q qualifies every entry,
  // so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = (count_q == 2'd0) ? push_data : mem_q[rd_ptr_q];
  assign full      = (count_q == 2'd2);
  assign empty     = (count_q == 2'd0);
  assign count     = count_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: one-outstanding-request memory FSM, redirect
// handling, a 2-entry response queue and the IF/ID pipeline register.
module if_fetch
  import rv_defs_pkg::*;
#(
  parameter word_t RESET_PC  = RV_RESET_PC,
  parameter word_t NOP_INSTR = RV_NOP
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            IFWrite,
  input  logic            Branch,
  input  logic            Jump,
  input  logic [XLEN-1:0] JumpAddr,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_valid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] Instruction_id,
  output logic [XLEN-1:0] PC_id
);

  fetch_state_t state_q, state_d;
  word_t        fetch_pc_q, fetch_pc_d;
  word_t        req_pc_q, req_pc_d;
  logic         imem_req_q, imem_req_d;
  word_t        instr_id_q, instr_id_d;
  word_t        pc_id_q, pc_id_d;

  logic         redirect, gnt_fire;
  word_t        target;
  logic         q_push, q_pop, q_full, q_empty;
  logic [1:0]   q_count, occ_d;
  fetch_entry_t q_head;

  assign redirect = (Branch | Jump) & IFWrite;
  assign target   = word_align(JumpAddr);
  assign gnt_fire = imem_req_q & imem_gnt;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    q_push     = 1'b0;

    case (state_q)
      FS_REQ: begin
        if (gnt_fire) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = redirect ? target : fetch_pc_q + 32'd4;
          state_d    = redirect ? FS_DISCARD : FS_WAIT;
        end else if (redirect) begin
          fetch_pc_d = target;
        end
      end
      FS_WAIT: begin
        if (redirect) begin
          fetch_pc_d = target;
          state_d    = imem_valid ? FS_REQ : FS_DISCARD;
        end else if (imem_valid) begin
          q_push  = ~q_full;
          state_d = FS_REQ;
        end
      end
      FS_DISCARD: begin
        if (redirect)   fetch_pc_d = target;
        if (imem_valid) state_d    = FS_REQ;
      end
      default: state_d = FS_REQ;
    endcase

    q_pop = IFWrite & ~redirect & (~q_empty | q_push);

    instr_id_d = instr_id_q;
    pc_id_d    = pc_id_q;
    if (IFWrite) begin
      instr_id_d = q_pop ? q_head.instr : NOP_INSTR;
      pc_id_d    = q_pop ? q_head.pc    : '0;
    end

    // Request only while the queue will still have room for the response.
    occ_d = q_count;
    case ({q_push, q_pop})
      2'b10:   occ_d = q_count + 2'd1;
      2'b01:   occ_d = q_count - 2'd1;
      default: occ_d = q_count;
    endcase
    if (redirect) occ_d = 2'd0;
    imem_req_d = (state_d == FS_REQ) && (occ_d != 2'd2);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FS_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      imem_req_q <= 1'b0;
      instr_id_q <= NOP_INSTR;
      pc_id_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      imem_req_q <= imem_req_d;
      instr_id_q <= instr_id_d;
      pc_id_q    <= pc_id_d;
    end
  end

  fetch_queue u_fetch_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .pop       (q_pop),
    .flush     (redirect),
    .push_data ('{pc: req_pc_q, instr: imem_rdata}),
    .head_data (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign imem_req       = imem_req_q;
  assign imem_addr      = fetch_pc_q;
  assign Instruction_id = instr_id_q;
  assign PC_id          = pc_id_q;

endmodule
